// File: rtl/resistor_load_pkg.sv
// resistor_load_pkg: shared types and widths for the resistor-load sweep controller.
package resistor_load_pkg;

  localparam int IDX_W  = 8;
  localparam int FAIL_W = 16;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_DRIVE  = 3'd1,
    S_SETTLE = 3'd2,
    S_SAMPLE = 3'd3,
    S_NEXT   = 3'd4,
    S_DONE   = 3'd5
  } rload_state_e;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [FAIL_W-1:0] sat_inc(input logic [FAIL_W-1:0] v);
    return (&v) ? v : v + FAIL_W'(1);
  endfunction

endpackage

// File: rtl/resistor_load_sweep_ctrl_index_counter.sv
// sweep_index_counter: 2-D wrap counter. idx_b is the fast axis, idx_a the slow axis.
// o_last flags the final grid point (N_STEPS-1, N_STEPS-1).
module sweep_index_counter
  import resistor_load_pkg::*;
#(
  parameter int N_STEPS = 21
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_clr,
  input  logic             i_inc,
  output logic [IDX_W-1:0] o_idx_a,
  output logic [IDX_W-1:0] o_idx_b,
  output logic             o_last
);

  localparam logic [IDX_W-1:0] LAST = IDX_W'(N_STEPS - 1);

  logic [IDX_W-1:0] r_idx_a;
  logic [IDX_W-1:0] r_idx_b;
  logic             w_b_wrap;

  assign w_b_wrap = (r_idx_b == LAST);

  // Step the fast axis; carry into the slow axis when the fast axis wraps.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      r_idx_a <= '0;
      r_idx_b <= '0;
    end else if (i_inc) begin
      if (w_b_wrap) begin
        r_idx_b <= '0;
        r_idx_a <= (r_idx_a == LAST) ? '0 : r_idx_a + IDX_W'(1);
      end else begin
        r_idx_b <= r_idx_b + IDX_W'(1);
      end
    end
  end

  assign o_idx_a = r_idx_a;
  assign o_idx_b = r_idx_b;
  assign o_last  = w_b_wrap && (r_idx_a == LAST);

endmodule

// File: rtl/resistor_load_sweep_ctrl.sv
// resistor_load_sweep_ctrl: sequences Iin/Iinb over an N_STEPS x N_STEPS grid, settles,
// samples vout-voutb and counts points outside the +/-VDIFF_MAX window.
// Defining RLOAD_VSS_SWEEP_EN appends a vssana sweep phase after the current grid.
module resistor_load_sweep_ctrl
  import resistor_load_pkg::*;
#(
  parameter int  N_STEPS    = 21,
  parameter int  SETTLE_CYC = 4,
  parameter real I_MIN      = -1.0e-3,
  parameter real I_STEP     = 0.1e-3,
  parameter real VDIFF_MAX  = 0.5
`ifdef RLOAD_VSS_SWEEP_EN
  ,
  parameter int  N_VSS      = 11,
  parameter real VSS_MIN    = -0.05,
  parameter real VSS_STEP   = 0.01
`endif
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic              i_abort,
  output real               o_iin,
  output real               o_iinb,
  output real               o_vssana,
  input  real               i_vout,
  input  real               i_voutb,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_sample_valid,
  output logic [IDX_W-1:0]  o_idx_a,
  output logic [IDX_W-1:0]  o_idx_b,
  output real               o_vdiff,
  output logic [FAIL_W-1:0] o_fail_cnt
);

  localparam int               SET_W    = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [SET_W-1:0] SET_LOAD = SET_W'(SETTLE_CYC - 1);

  rload_state_e      r_state;
  rload_state_e      w_state_next;
  logic [SET_W-1:0]  r_settle_cnt;
  logic              r_sample_valid;
  logic [FAIL_W-1:0] r_fail_cnt;
  real               r_iin;
  real               r_iinb;
  real               r_vdiff;
  real               w_vdiff;
  logic              w_idx_clr;
  logic              w_idx_inc;
  logic              w_idx_last;
  logic              w_abort_act;
  logic              w_vss_phase;
  logic              w_vss_last;
  logic [IDX_W-1:0]  w_idx_a;
  logic [IDX_W-1:0]  w_idx_b;

  assign w_vdiff     = i_vout - i_voutb;
  assign w_abort_act = i_abort && (r_state != S_IDLE);

  sweep_index_counter #(
    .N_STEPS (N_STEPS)
  ) u_idx (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_clr   (w_idx_clr),
    .i_inc   (w_idx_inc),
    .o_idx_a (w_idx_a),
    .o_idx_b (w_idx_b),
    .o_last  (w_idx_last)
  );

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic; abort from any active state overrides everything else.
  always_comb begin
    w_state_next = r_state;
    w_idx_clr    = 1'b0;
    w_idx_inc    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_start && !i_abort) begin
          w_state_next = S_DRIVE;
          w_idx_clr    = 1'b1;
        end
      end
      S_DRIVE:  w_state_next = S_SETTLE;
      S_SETTLE: if (r_settle_cnt == '0) w_state_next = S_SAMPLE;
      S_SAMPLE: w_state_next = S_NEXT;
      S_NEXT: begin
        if (w_vss_phase) begin
          w_state_next = w_vss_last ? S_DONE : S_DRIVE;
        end else if (w_idx_last) begin
`ifdef RLOAD_VSS_SWEEP_EN
          w_state_next = S_DRIVE;
`else
          w_state_next = S_DONE;
`endif
        end else begin
          w_idx_inc    = 1'b1;
          w_state_next = S_DRIVE;
        end
      end
      S_DONE:   w_state_next = S_IDLE;
      default:  w_state_next = S_IDLE;
    endcase
    if (w_abort_act) begin
      w_state_next = S_IDLE;
      w_idx_inc    = 1'b0;
    end
  end

  // Drive currents, settle timer, sample capture and fail counting.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_iin          <= 0.0;
      r_iinb         <= 0.0;
      r_vdiff        <= 0.0;
      r_sample_valid <= 1'b0;
      r_fail_cnt     <= '0;
      r_settle_cnt   <= '0;
    end else begin
      r_sample_valid <= 1'b0;
      if (w_abort_act) begin
        r_iin  <= 0.0;
        r_iinb <= 0.0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (w_idx_clr) r_fail_cnt <= '0;
          end
          S_DRIVE: begin
            // Currents are computed from the integer indices so nothing accumulates.
            if (w_vss_phase) begin
              r_iin  <= 0.0;
              r_iinb <= 0.0;
            end else begin
              r_iin  <= I_MIN + real'(w_idx_a) * I_STEP;
              r_iinb <= I_MIN + real'(w_idx_b) * I_STEP;
            end
            r_settle_cnt <= SET_LOAD;
          end
          S_SETTLE: begin
            if (r_settle_cnt != '0) r_settle_cnt <= r_settle_cnt - SET_W'(1);
          end
          S_SAMPLE: begin
            r_vdiff        <= w_vdiff;
            r_sample_valid <= 1'b1;
            if ((w_vdiff > VDIFF_MAX) || (w_vdiff < -VDIFF_MAX)) begin
              r_fail_cnt <= sat_inc(r_fail_cnt);
            end
          end
          default: ;
        endcase
      end
    end
  end

`ifdef RLOAD_VSS_SWEEP_EN
  localparam logic [IDX_W-1:0] VSS_LAST = IDX_W'(N_VSS - 1);

  logic             r_vss_phase;
  logic [IDX_W-1:0] r_vss_k;
  real              r_vssana;

  // vssana phase: entered after the last grid point, steps k and drives the reference.
  always_ff @(posedge i_clk) begin
    if (i_rst || w_idx_clr || w_abort_act) begin
      r_vss_phase <= 1'b0;
      r_vss_k     <= '0;
      r_vssana    <= 0.0;
    end else begin
      if (r_state == S_DRIVE && r_vss_phase) begin
        r_vssana <= VSS_MIN + real'(r_vss_k) * VSS_STEP;
      end
      if (r_state == S_NEXT) begin
        if (!r_vss_phase) begin
          if (w_idx_last) r_vss_phase <= 1'b1;
        end else if (!w_vss_last) begin
          r_vss_k <= r_vss_k + IDX_W'(1);
        end
      end
    end
  end

  assign w_vss_phase = r_vss_phase;
  assign w_vss_last  = (r_vss_k == VSS_LAST);
  assign o_vssana    = r_vssana;
  assign o_idx_a     = r_vss_phase ? '1 : w_idx_a;
  assign o_idx_b     = r_vss_phase ? r_vss_k : w_idx_b;
`else
  assign w_vss_phase = 1'b0;
  assign w_vss_last  = 1'b1;
  assign o_vssana    = 0.0;
  assign o_idx_a     = w_idx_a;
  assign o_idx_b     = w_idx_b;
`endif

  assign o_iin          = r_iin;
  assign o_iinb         = r_iinb;
  assign o_vdiff        = r_vdiff;
  assign o_sample_valid = r_sample_valid;
  assign o_fail_cnt     = r_fail_cnt;
  assign o_busy         = (r_state != S_IDLE) && (r_state != S_DONE);
  assign o_done         = (r_state == S_DONE);

endmodule

// File: tb/tb_resistor_load_sweep_ctrl.sv
// tb_resistor_load_sweep_ctrl: directed checks of the sweep sequencer on a 3x3 grid,
// settle time 2 and a zero-width pass window. Load model: vout = 1000*Iin + delta, voutb = 1000*Iin.
module tb_resistor_load_sweep_ctrl;
  import resistor_load_pkg::*;

  localparam int N = 3;
  localparam int S = 2;
`ifdef RLOAD_VSS_SWEEP_EN
  localparam int NPTS = N * N + 11;
`else
  localparam int NPTS = N * N;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              abort;
  real               iin;
  real               iinb;
  real               vssana;
  real               vout;
  real               voutb;
  real               vdiff;
  real               delta;
  logic              busy;
  logic              done;
  logic              sv;
  logic [IDX_W-1:0]  idx_a;
  logic [IDX_W-1:0]  idx_b;
  logic [FAIL_W-1:0] fail_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  // Simple differential load: output difference is exactly delta.
  always_comb begin
    vout  = 1000.0 * iin + delta;
    voutb = 1000.0 * iin;
  end

  resistor_load_sweep_ctrl #(
    .N_STEPS    (N),
    .SETTLE_CYC (S),
    .VDIFF_MAX  (0.0)
  ) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_start        (start),
    .i_abort        (abort),
    .o_iin          (iin),
    .o_iinb         (iinb),
    .o_vssana       (vssana),
    .i_vout         (vout),
    .i_voutb        (voutb),
    .o_busy         (busy),
    .o_done         (done),
    .o_sample_valid (sv),
    .o_idx_a        (idx_a),
    .o_idx_b        (idx_b),
    .o_vdiff        (vdiff),
    .o_fail_cnt     (fail_cnt)
  );

  task automatic check_val(input string tag, input longint got, input longint exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Real value in micro-units, rounded to nearest.
  function automatic longint to_u(input real r);
    real s;
    s = r * 1.0e6;
    if (s >= 0.0) return longint'($rtoi(s + 0.5));
    else          return longint'($rtoi(s - 0.5));
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full sweep from a start pulse; optional stray start pulse at cycle 'poke'.
  task automatic run_sweep(input real d, input int poke, input int exp_fail);
    int n_sv;
    int n_done;
    int done_cyc;
    int ea, eb, ei, eib, ev;
    delta    = d;
    n_sv     = 0;
    n_done   = 0;
    done_cyc = -1;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int cyc = 1; cyc <= 5 * NPTS + 20 && n_done == 0; cyc++) begin
      if (cyc == poke) start = 1'b1;
      tick();
      start = 1'b0;
      if (sv) begin
        if (n_sv < N * N) begin
          ea = n_sv / N; eb = n_sv % N;
          ei = -1000 + 100 * ea; eib = -1000 + 100 * eb; ev = 0;
        end else begin
          ea = 255; eb = n_sv - N * N;
          ei = 0; eib = 0; ev = -50000 + 10000 * eb;
        end
        check_val("sv_time", cyc, (S + 2) + (S + 3) * n_sv);
        check_val("sv_busy", busy, 1);
        check_val("idx_a", idx_a, ea);
        check_val("idx_b", idx_b, eb);
        check_val("iin_uA", to_u(iin), ei);
        check_val("iinb_uA", to_u(iinb), eib);
        check_val("vssana_uV", to_u(vssana), ev);
        check_val("vdiff_uV", to_u(vdiff), to_u(d));
        $display("sample %0d: cyc=%0d idx=(%0d,%0d) iin=%0d iinb=%0d vdiff=%0d fail=%0d",
                 n_sv, cyc, idx_a, idx_b, to_u(iin), to_u(iinb), to_u(vdiff), fail_cnt);
        n_sv++;
      end
      if (done) begin
        n_done++;
        done_cyc = cyc;
        check_val("done_busy", busy, 0);
      end
    end
    check_val("sv_count", n_sv, NPTS);
    check_val("done_count", n_done, 1);
    check_val("done_cyc", done_cyc, (S + 3) * NPTS);
    check_val("fail_at_done", fail_cnt, exp_fail);
`ifdef RLOAD_VSS_SWEEP_EN
    check_val("iin_hold", to_u(iin), 0);
    check_val("vssana_last", to_u(vssana), 50000);
`else
    check_val("iin_hold", to_u(iin), -1000 + 100 * (N - 1));
    check_val("vssana_last", to_u(vssana), 0);
`endif
    tick();
    check_val("done_pulse", done, 0);
    check_val("idle_busy", busy, 0);
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    delta = 0.0;
    tick();
    tick();
    rst = 1'b0;
    tick();

    // Reset state
    check_val("rst_busy", busy, 0);
    check_val("rst_done", done, 0);
    check_val("rst_sv", sv, 0);
    check_val("rst_idx_a", idx_a, 0);
    check_val("rst_idx_b", idx_b, 0);
    check_val("rst_fail", fail_cnt, 0);
    check_val("rst_iin", to_u(iin), 0);
    check_val("rst_iinb", to_u(iinb), 0);
    check_val("rst_vssana", to_u(vssana), 0);
    check_val("rst_vdiff", to_u(vdiff), 0);

    // Ideal load: vdiff exactly at the window edge, no fails
    run_sweep(0.0, 0, 0);

    // Offset load: every point fails
    run_sweep(0.1, 0, NPTS);

    // Start clears fail count; abort during the third settle
    start = 1'b1;
    tick();
    start = 1'b0;
    check_val("start_clr_fail", fail_cnt, 0);
    check_val("start_busy", busy, 1);
    repeat (12) tick();
    check_val("pre_abort_busy", busy, 1);
    check_val("pre_abort_fail", fail_cnt, 2);
    check_val("pre_abort_idx_b", idx_b, 2);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check_val("abort_busy", busy, 0);
    check_val("abort_done", done, 0);
    check_val("abort_iin", to_u(iin), 0);
    check_val("abort_iinb", to_u(iinb), 0);
    check_val("abort_fail", fail_cnt, 2);
    for (int i = 0; i < 8; i++) begin
      tick();
      check_val("abort_quiet", {busy, done, sv}, 0);
    end

    // Fresh start after abort, then reset while in SAMPLE
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (8) tick();
    check_val("pre_rst_idx_a", idx_a, 0);
    check_val("pre_rst_idx_b", idx_b, 1);
    check_val("pre_rst_fail", fail_cnt, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_val("mid_rst_sv", sv, 0);
    check_val("mid_rst_busy", busy, 0);
    check_val("mid_rst_idx_b", idx_b, 0);
    check_val("mid_rst_fail", fail_cnt, 0);
    check_val("mid_rst_iin", to_u(iin), 0);
    check_val("mid_rst_iinb", to_u(iinb), 0);
    check_val("mid_rst_vdiff", to_u(vdiff), 0);
    tick();
    check_val("post_rst_sv", sv, 0);
    check_val("post_rst_busy", busy, 0);

    // Stray start while busy leaves the sweep unaffected
    run_sweep(0.0, 7, 0);

    // start and abort together in IDLE: stays idle
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    check_val("sa_busy", busy, 0);
    for (int i = 0; i < 6; i++) begin
      tick();
      check_val("sa_quiet", {busy, done, sv}, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
